sync_bus_stabilizer: RTL
========================

# sync_bus_stabilizer

Single-clock destination-domain stage that consumes a multi-bit bus after bit-wise synchronization (`xpm_cdc_array_single` `dest_out`). Per-bit synchronizers can present transient mixed-bit codes, so this block accepts a new word only after it has held unchanged for `STABLE_CYCLES` consecutive samples. Each accepted word is delivered once over a valid/ready interface to downstream pixel-buffer control logic.

## Interface
- `WIDTH`, default 8: bus width in bits.
- `STABLE_CYCLES`, default 4: consecutive identical samples required for acceptance; legal range ≥1.
- `CNT_WIDTH`, default 16: glitch counter width; used only with the configuration macro.

- `dest_clk`  in  1: the single clock for the block.
- `dest_rst_n`  in  1: reset; asynchronous, active-low.
- `sync_in`  in  WIDTH: synchronized bus from the upstream CDC array.
- `out_data`  out  WIDTH: last accepted word.
- `out_valid`  out  1: an accepted word is pending.
- `out_ready`  in  1: consumer takes `out_data` at an edge where `out_valid`=1.
- `overrun`  out  1: sticky flag; a pending word was overwritten before it was taken.
- `overrun_clr`  in  1: synchronous clear for `overrun`.
- `glitch_cnt`  out  CNT_WIDTH: present only with the configuration macro.

## Operation
- Internal registers:
  - `prev`: last sample, WIDTH bits.
  - `cnt`: stability counter, $clog2(STABLE_CYCLES+1) bits.
  - `committed`: last accepted word.
- Reset values:
  - `prev`=0, `committed`=0, `cnt`=STABLE_CYCLES (saturated).
  - `out_data`=0, `out_valid`=0, `overrun`=0, `glitch_cnt`=0.
  - Consequence: a bus that remains 0 after reset produces no output.
- Per-edge tracking:
  - `sync_in`≠`prev`: `prev`←`sync_in`, `cnt`←0.
  - Otherwise, `cnt`<STABLE_CYCLES: `cnt`←`cnt`+1. `cnt` saturates at STABLE_CYCLES.
- Accept event: `sync_in`==`prev` AND `cnt`==STABLE_CYCLES−1 AND `prev`≠`committed`. On accept:
  - `committed`←`prev`, `out_data`←`prev`, `out_valid`←1.
- Return to the committed value after a glitch: the word settles, but no accept fires because `prev`==`committed`.
- Handshake: an edge with `out_valid`&`out_ready` and no accept clears `out_valid`. `out_data` holds its value.
- Accept and handshake at the same edge: `out_data` takes the new word, `out_valid` stays 1, `overrun` is unchanged.
- Accept with `out_valid`=1 and `out_ready`=0: `out_data` is overwritten, `overrun`←1.
- `overrun_clr`: clears `overrun`. If a set condition occurs at the same edge, set wins.
- `out_ready` while `out_valid`=0 has no effect.

## Timing
- Let edge t be the first edge that samples a new value V, with V held from then on. `out_valid` rises after edge t+STABLE_CYCLES; latency is STABLE_CYCLES cycles.
- A change arriving before t+STABLE_CYCLES restarts the count from the new value. The earlier value is never accepted.
- `out_valid` falls after the handshake edge. Minimum spacing between two accepts is STABLE_CYCLES+1 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset mid-settle or mid-handshake: all state returns to reset values immediately (asynchronously). A pending word is discarded.

## Configuration
- `SYNC_BUS_STABILIZER_GLITCH_CNT_EN` defined:
  - The `glitch_cnt` port and counter exist.
  - The counter increments on every edge where `sync_in`≠`prev` and `cnt`<STABLE_CYCLES, i.e. a value abandoned before it became stable.
  - The counter saturates at all-ones and is cleared only by reset.
- Macro undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8 and STABLE_CYCLES=4.
- Reset, `sync_in`=0x00 for 10 cycles → `out_valid`=0, `out_data`=0x00, `overrun`=0 throughout.
- `sync_in` 0x00→0xA5 first sampled at edge t and held, `out_ready`=0 → `out_valid`=1 and `out_data`=0xA5 after edge t+4. Then `out_ready`=1 for one edge → `out_valid`=0, and no further valid while 0xA5 is held.
- 0x3C for 2 cycles, then 0x3F held → exactly one valid, with 0x3F, after edge t+6. 0x3C is never output. `glitch_cnt`=1 with the macro.
- `out_ready`=0: accept 0x11, then 0x22 → `out_data`=0x22, `overrun`=1. Pulse `overrun_clr` → `overrun`=0. Assert `out_ready` → valid drops.
- 0x55 accepted and taken, then 0x56 for 2 cycles, then back to 0x55 held → no new `out_valid`. `glitch_cnt` increments by 1.
- Assert `dest_rst_n` low while `cnt`=2 during settling of 0x77, release with `sync_in`=0x00 → outputs 0 immediately, no `out_valid` afterwards.

Source files
------------

// File: rtl/sync_bus_stabilizer.sv
// Accepts a word from a bit-wise synchronized bus only after it has held steady, and hands
// each new word downstream once over valid/ready. Optional macro: SYNC_BUS_STABILIZER_GLITCH_CNT_EN.
module sync_bus_stabilizer #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic             dest_clk,
  input  logic             dest_rst_n,
  input  logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             overrun_clr
`ifdef SYNC_BUS_STABILIZER_GLITCH_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] glitch_cnt
`endif
);

  localparam int            CW     = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] C_SAT  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] C_LAST = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_committed;
  logic [CW-1:0]    r_cnt;

  logic w_same;
  logic w_accept;
  logic w_take;

  assign w_same   = (sync_in == r_prev);
  // Settling back onto the already-committed word must not re-deliver it.
  assign w_accept = w_same && (r_cnt == C_LAST) && (r_prev != r_committed);
  assign w_take   = out_valid && out_ready;

  // Stage: sample tracking and stability count
  always_ff @(posedge dest_clk or negedge dest_rst_n) begin
    if (!dest_rst_n) begin
      r_prev <= '0;
      r_cnt  <= C_SAT;
    end else if (!w_same) begin
      r_prev <= sync_in;
      r_cnt  <= '0;
    end else if (r_cnt < C_SAT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Stage: commit and downstream handshake
  always_ff @(posedge dest_clk or negedge dest_rst_n) begin
    if (!dest_rst_n) begin
      r_committed <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_committed <= r_prev;
        out_data    <= r_prev;
        out_valid   <= 1'b1;
      end else if (w_take) begin
        out_valid <= 1'b0;
      end
      if (w_accept && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef SYNC_BUS_STABILIZER_GLITCH_CNT_EN
  logic w_abandon;

  // A value dropped before it reached full stability counts as one glitch.
  assign w_abandon = !w_same && (r_cnt < C_SAT);

  always_ff @(posedge dest_clk or negedge dest_rst_n) begin
    if (!dest_rst_n) begin
      glitch_cnt <= '0;
    end else if (w_abandon && (glitch_cnt != {CNT_WIDTH{1'b1}})) begin
      glitch_cnt <= glitch_cnt + 1'b1;
    end
  end
`else
  logic w_unused_cnt_width;
  assign w_unused_cnt_width = (CNT_WIDTH != 0);
`endif

endmodule
